// File: rtl/reg_wb_ctrl_pkg.sv
// Shared definitions for the register writeback controller:
// last-grant encoding, register/data widths and the queue entry layout.
package reg_wb_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned INT_W      = 8;
  localparam int unsigned DOM_W      = 8;
  localparam int unsigned WB_ADDR_W  = REG_ADDR_W + 1;
  localparam int unsigned PEND_W     = 1 << WB_ADDR_W;

  typedef enum logic {
    LG_INT = 1'b0,
    LG_RNS = 1'b1
  } last_grant_e;

  // Queue entry layout, MSB to LSB: {rns, addr[REG_ADDR_W-1:0], data[data_w-1:0]}
  function automatic int unsigned entry_w(input int unsigned data_w);
    return 1 + REG_ADDR_W + data_w;
  endfunction

  function automatic int unsigned entry_addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned entry_rns_bit(input int unsigned data_w);
    return data_w + REG_ADDR_W;
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// In-order writeback queue: DEPTH entries of WIDTH bits, pointers wrap
// modulo DEPTH (power of two), occupancy held in a log2(DEPTH)+1 bit counter.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on occupancy before any same-cycle pop.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rd_ptr];
  end

  // Entry storage; contents need no reset, occupancy gates validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register writeback controller: arbitrates integer and RNS results into an
// in-order queue and drains one register-file write per cycle.
// Optional pending-write scoreboard enabled by defining WB_SCOREBOARD_EN.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         int_valid,
  input  logic [REG_ADDR_W-1:0]        int_addr,
  input  logic [INT_W-1:0]             int_data,
  output logic                         int_ready,
  input  logic                         rns_valid,
  input  logic [REG_ADDR_W-1:0]        rns_addr,
  input  logic [NUM_DOMAINS*DOM_W-1:0] rns_data,
  output logic                         rns_ready,
  input  logic                         issue_valid,
  input  logic [WB_ADDR_W-1:0]         issue_addr,
  output logic [PEND_W-1:0]            pending,
  output logic                         wr_en,
  output logic [WB_ADDR_W-1:0]         wr_addr,
  output logic [NUM_DOMAINS*DOM_W-1:0] wr_data,
  output logic                         wr_RNS,
  output logic                         idle
);

  localparam int unsigned DATA_W = NUM_DOMAINS * DOM_W;
  localparam int unsigned ENT_W  = entry_w(DATA_W);
  localparam int unsigned A_LSB  = entry_addr_lsb(DATA_W);
  localparam int unsigned R_BIT  = entry_rns_bit(DATA_W);

  last_grant_e      last_grant;
  logic             push;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;

  // Round-robin grant between the two producers; the source not granted last wins a tie.
  always_comb begin
    int_ready  = 1'b0;
    rns_ready  = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (!reset && !fifo_full) begin
      if (int_valid && (!rns_valid || last_grant == LG_RNS)) begin
        int_ready = 1'b1;
      end else if (rns_valid) begin
        rns_ready = 1'b1;
      end
    end
    push = int_ready | rns_ready;
    if (rns_ready) begin
      push_entry = {1'b1, rns_addr, rns_data};
    end else begin
      push_entry = {1'b0, int_addr, DATA_W'(int_data)};
    end
  end

  // Last-grant state follows each winner; reset favours the integer side on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LG_RNS;
    end else if (int_ready) begin
      last_grant <= LG_INT;
    end else if (rns_ready) begin
      last_grant <= LG_RNS;
    end
  end

  wb_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (~fifo_empty),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write port: the queue head is popped every non-empty cycle and driven the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_RNS  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= ~fifo_empty;
      if (!fifo_empty) begin
        wr_RNS  <= head[R_BIT];
        wr_addr <= {head[R_BIT], head[A_LSB +: REG_ADDR_W]};
        wr_data <= head[DATA_W-1:0];
      end
    end
  end

  // Idle when nothing is queued or being written; forced high while in reset.
  always_comb begin
    idle = reset | (fifo_empty & ~wr_en);
  end

`ifdef WB_SCOREBOARD_EN
  logic [PEND_W-1:0] pending_nxt;

  // Issue sets and completed writes clear; a same-index set overrides the clear.
  always_comb begin
    pending_nxt = pending;
    if (wr_en) pending_nxt[wr_addr] = 1'b0;
    if (issue_valid) pending_nxt[issue_addr] = 1'b1;
  end

  // Pending-write flags register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end
`else
  logic unused_issue;

  // Scoreboard absent: flags tied off and issue inputs deliberately ignored.
  assign pending      = '0;
  assign unused_issue = ^{issue_valid, issue_addr};
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: a grant model predicts readys and
// queues the expected writes, a monitor pops and compares each write.
module tb_reg_wb_ctrl;
  import reg_wb_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        int_valid;
  logic [2:0]  int_addr;
  logic [7:0]  int_data;
  logic        int_ready;
  logic        rns_valid;
  logic [2:0]  rns_addr;
  logic [15:0] rns_data;
  logic        rns_ready;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic [15:0] pending;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_RNS;
  logic        idle;

  int          vectors = 0;
  int          errors  = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  last_grant_e m_last;

  reg_wb_ctrl #(
    .NUM_DOMAINS(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .int_valid  (int_valid),
    .int_addr   (int_addr),
    .int_data   (int_data),
    .int_ready  (int_ready),
    .rns_valid  (rns_valid),
    .rns_addr   (rns_addr),
    .rns_data   (rns_data),
    .rns_ready  (rns_ready),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .pending    (pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_RNS     (wr_RNS),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offer one cycle of producer inputs, check the predicted grant, queue the expected write.
  task automatic drive_cycle(input logic iv, input logic [2:0] ia, input logic [7:0] id,
                             input logic rv, input logic [2:0] ra, input logic [15:0] rd);
    logic g_int;
    logic g_rns;
    int_valid = iv; int_addr = ia; int_data = id;
    rns_valid = rv; rns_addr = ra; rns_data = rd;
    g_int = iv && (!rv || m_last == LG_RNS);
    g_rns = rv && !g_int;
    @(negedge clk);
    check("int_ready", 32'(int_ready), 32'(g_int));
    check("rns_ready", 32'(rns_ready), 32'(g_rns));
    if (g_int) begin
      exp_q.push_back({1'b0, ia, 16'(id)});
      m_last = LG_INT;
    end else if (g_rns) begin
      exp_q.push_back({1'b1, ra, rd});
      m_last = LG_RNS;
    end
    @(posedge clk); #1;
    int_valid = 1'b0;
    rns_valid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_last = LG_RNS;
  endtask

  // Every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_entry", 32'({wr_RNS, wr_addr, wr_data}), 32'({mon_e[19], mon_e}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    int_valid = 1'b1; int_addr = 3'd7; int_data = 8'hFF;
    rns_valid = 1'b1; rns_addr = 3'd1; rns_data = 16'hFFFF;
    issue_valid = 1'b0; issue_addr = 4'h0;
    m_last = LG_RNS;

    // Reset state, readys held low while reset is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_int_ready", 32'(int_ready), 32'd0);
    check("rst_rns_ready", 32'(rns_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; int_valid = 1'b0; rns_valid = 1'b0;

    // Single integer write: latency and idle
    drive_cycle(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 16'h0);
    check("lat_wr_en_early", 32'(wr_en), 32'd0);
    check("lat_idle_busy", 32'(idle), 32'd0);
    @(posedge clk); #1;
    check("lat_wr_en", 32'(wr_en), 32'd1);
    check("lat_wr_addr", 32'(wr_addr), 32'h3);
    check("lat_wr_rns", 32'(wr_RNS), 32'd0);
    check("lat_wr_data", 32'(wr_data), 32'h00A5);
    @(posedge clk); #1;
    check("lat_wr_en_off", 32'(wr_en), 32'd0);
    check("lat_idle_back", 32'(idle), 32'd1);

    // Both producers every cycle: grants alternate starting with INT
    reset_dut();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 3'd1, 8'h11, 1'b1, 3'd5, 16'h2233);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back integer results drain one write per cycle
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 3'(i), 8'h40 + 8'(i), 1'b0, 3'd0, 16'h0);
      if (i > 0) check("b2b_wr_en", 32'(wr_en), 32'd1);
    end
    @(posedge clk); #1;
    check("b2b_last_wr_en", 32'(wr_en), 32'd1);
    @(posedge clk); #1;
    check("b2b_done_wr_en", 32'(wr_en), 32'd0);

`ifdef WB_SCOREBOARD_EN
    // Pending set by issue, cleared by the write
    issue_valid = 1'b1; issue_addr = 4'hA;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    check("pend_set", 32'(pending), 32'h0400);
    drive_cycle(1'b0, 3'd0, 8'h0, 1'b1, 3'd2, 16'h1234);
    @(posedge clk); #1;
    check("pend_wr_en", 32'(wr_en), 32'd1);
    check("pend_hold", 32'(pending), 32'h0400);
    @(posedge clk); #1;
    check("pend_clr", 32'(pending), 32'h0000);
    // Re-issue in the clear cycle: set wins
    issue_valid = 1'b1; issue_addr = 4'hA;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    drive_cycle(1'b0, 3'd0, 8'h0, 1'b1, 3'd2, 16'h5678);
    @(posedge clk); #1;
    check("pend_wr_en2", 32'(wr_en), 32'd1);
    issue_valid = 1'b1; issue_addr = 4'hA;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    check("pend_set_wins", 32'(pending), 32'h0400);
`else
    // Scoreboard absent: issue traffic has no effect
    for (int i = 0; i < 8; i++) begin
      issue_valid = i[0]; issue_addr = 4'(i * 3);
      @(posedge clk); #1;
      check("pend_const", 32'(pending), 32'h0000);
    end
    issue_valid = 1'b0;
`endif

    // Reset mid-operation discards the queued entry
    drive_cycle(1'b1, 3'd4, 8'h71, 1'b0, 3'd0, 16'h0);
    drive_cycle(1'b1, 3'd5, 8'h72, 1'b0, 3'd0, 16'h0);
    drive_cycle(1'b1, 3'd6, 8'h73, 1'b0, 3'd0, 16'h0);
    reset = 1'b1; int_valid = 1'b1; int_addr = 3'd7; int_data = 8'h74;
    @(negedge clk);
    check("mid_rst_int_ready", 32'(int_ready), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; int_valid = 1'b0;
    exp_q.delete();
    m_last = LG_RNS;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'h0000);
    check("mid_rst_idle_after", 32'(idle), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_wr", 32'(wr_en), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
